// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the runtime-configurable serial pattern detector.
package seqdet_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1011;
    localparam int         DEFAULT_LEN     = 4;

    // Width needed to hold a matched-prefix length of 0..maxW.
    function automatic int progWidth(input int maxW);
        return $clog2(maxW + 1);
    endfunction

endpackage

// File: rtl/seqdet_prefix_match.sv
// Combinational next-state search: longest pattern prefix that ends the updated history.
module seqdet_prefix_match
    import seqdet_pkg::*;
#(
    parameter int MAX_W = 8
) (
    input  logic [MAX_W-1:0]              hist_i,
    input  logic [MAX_W-1:0]              pattern_i,
    input  logic [progWidth(MAX_W)-1:0]   len_i,
    input  logic [progWidth(MAX_W)-1:0]   kBase_i,
    output logic [progWidth(MAX_W)-1:0]   next_o
);

    localparam int             PW   = progWidth(MAX_W);
    localparam logic [MAX_W-1:0] ONES = '1;

    // Ascending scan where a later hit overrides, so the largest legal j wins.
    always_comb begin
        next_o = '0;
        for (int j = 1; j <= MAX_W; j++) begin
            if ((j <= int'(len_i)) && (j <= int'(kBase_i) + 1)) begin
                if ((hist_i & (ONES >> (MAX_W - j))) ==
                    ((pattern_i >> (int'(len_i) - j)) & (ONES >> (MAX_W - j)))) begin
                    next_o = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/seqdet_param.sv
// Serial pattern detector with loadable pattern/length and overlap select.
// Optional saturating match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seqdet_param
    import seqdet_pkg::*;
#(
    parameter int               MAX_W       = 8,
    parameter logic [MAX_W-1:0] DEF_PATTERN = MAX_W'(DEFAULT_PATTERN),
    parameter int               DEF_LEN     = DEFAULT_LEN,
    parameter int               CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          din,
    input  logic                          overlap,
    input  logic                          cfg_load,
    input  logic [MAX_W-1:0]              cfg_pattern,
    input  logic [progWidth(MAX_W)-1:0]   cfg_len,
    output logic                          match,
    output logic [progWidth(MAX_W)-1:0]   progress,
    output logic                          cfg_err,
    output logic [CNT_W-1:0]              match_count
);

    localparam int PW = progWidth(MAX_W);

    logic [MAX_W-1:0] pattern_q;
    logic [PW-1:0]    len_q;
    logic [PW-1:0]    progress_q;
    logic [PW-1:0]    progress_d;
    logic [PW-1:0]    kBase;
    // The oldest history bit is shifted out before it could ever be compared.
    logic [MAX_W-2:0] history_q;
    logic [MAX_W-1:0] history_d;
    logic             match_q;
    logic             cfgErr_q;
    logic             lenLegal;

    assign history_d = {history_q, din};
    assign kBase     = ((progress_q == len_q) && (overlap == MODE_NONOVL)) ? '0 : progress_q;
    assign lenLegal  = (cfg_len != '0) && (cfg_len <= PW'(MAX_W));

    seqdet_prefix_match #(
        .MAX_W (MAX_W)
    ) u_prefix (
        .hist_i    (history_d),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .kBase_i   (kBase),
        .next_o    (progress_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q  <= DEF_PATTERN;
            len_q      <= PW'(DEF_LEN);
            progress_q <= '0;
            history_q  <= '0;
            match_q    <= 1'b0;
            cfgErr_q   <= 1'b0;
        end else if (cfg_load) begin
            pattern_q  <= cfg_pattern;
            progress_q <= '0;
            history_q  <= '0;
            match_q    <= 1'b0;
            if (lenLegal) begin
                len_q <= cfg_len;
            end else begin
                len_q    <= PW'(MAX_W);
                cfgErr_q <= 1'b1;
            end
        end else if (en) begin
            history_q  <= history_d[MAX_W-2:0];
            progress_q <= progress_d;
            match_q    <= (progress_d == len_q);
        end else begin
            match_q <= 1'b0;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] matchCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matchCount_q <= '0;
        end else if (match_q && (matchCount_q != CNT_MAX)) begin
            matchCount_q <= matchCount_q + CNT_W'(1);
        end
    end

    assign match_count = matchCount_q;
`else
    assign match_count = '0;
`endif

    assign match    = match_q;
    assign progress = progress_q;
    assign cfg_err  = cfgErr_q;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed self-checking bench for seqdet_param (counter checks follow SEQDET_MATCH_CNT_EN).
module tb_seqdet_param;
    import seqdet_pkg::*;

    localparam int MAX_W = 8;
    localparam int PW    = progWidth(MAX_W);
    localparam int CNT_W = 2;
`ifdef SEQDET_MATCH_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             din;
    logic             overlap;
    logic             cfg_load;
    logic [MAX_W-1:0] cfg_pattern;
    logic [PW-1:0]    cfg_len;
    logic             match;
    logic [PW-1:0]    progress;
    logic             cfg_err;
    logic [CNT_W-1:0] match_count;

    int checkCount = 0;
    int errorCount = 0;

    // Stream 1,0,1,1,0,1,1 against pattern 1011
    int bitsA[7]     = '{1, 0, 1, 1, 0, 1, 1};
    int progOvlA[7]  = '{1, 2, 3, 4, 2, 3, 4};
    int matchOvlA[7] = '{0, 0, 0, 1, 0, 0, 1};
    int progNonA[7]  = '{1, 2, 3, 4, 0, 1, 1};
    int matchNonA[7] = '{0, 0, 0, 1, 0, 0, 0};
    // Pattern 111, five ones
    int prog111Ovl[5]  = '{1, 2, 3, 3, 3};
    int match111Ovl[5] = '{0, 0, 1, 1, 1};
    int prog111Non[5]  = '{1, 2, 3, 1, 2};
    int match111Non[5] = '{0, 0, 1, 0, 0};
    // Gapped 1011 stream; disabled cycles carry misleading din
    int enG[9]    = '{1, 0, 0, 1, 1, 0, 1, 0, 1};
    int dinG[9]   = '{1, 0, 1, 0, 1, 0, 1, 1, 0};
    int progG[9]  = '{1, 1, 1, 2, 3, 3, 4, 4, 2};
    int matchG[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};

    seqdet_param #(
        .MAX_W (MAX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .din         (din),
        .overlap     (overlap),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .match       (match),
        .progress    (progress),
        .cfg_err     (cfg_err),
        .match_count (match_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic d);
        en       = e;
        din      = d;
        cfg_load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic stepCheck(input string tag, input logic e, input logic d, input int expProg, input int expMatch);
        applyStimulus(e, d);
        checkOutput({tag, "_prog"}, 32'(progress), 32'(expProg));
        checkOutput({tag, "_match"}, 32'(match), 32'(expMatch));
    endtask

    task automatic loadConfig(input logic [MAX_W-1:0] pat, input logic [PW-1:0] len);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_load    = 1'b1;
        en          = 1'b1;
        din         = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        en       = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        din         = 1'b0;
        overlap     = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        #1;
        checkOutput("rst_prog", 32'(progress), 0);
        checkOutput("rst_match", 32'(match), 0);
        checkOutput("rst_cfg_err", 32'(cfg_err), 0);
        checkOutput("rst_count", 32'(match_count), 0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default 1011, overlapping
        for (int i = 0; i < 7; i++)
            stepCheck($sformatf("ovl1011[%0d]", i), 1'b1, 1'(bitsA[i]), progOvlA[i], matchOvlA[i]);
        stepCheck("ovl1011_idle", 1'b0, 1'b1, 4, 0);
        checkOutput("ovl1011_count", 32'(match_count), 32'(CNT_ON * 2));

        // Same stream, non-overlapping
        doReset();
        overlap = 1'b0;
        for (int i = 0; i < 7; i++)
            stepCheck($sformatf("non1011[%0d]", i), 1'b1, 1'(bitsA[i]), progNonA[i], matchNonA[i]);
        stepCheck("non1011_idle", 1'b0, 1'b0, 1, 0);
        checkOutput("non1011_count", 32'(match_count), 32'(CNT_ON * 1));

        // Pattern 111 with junk bits above len; load discards its din
        doReset();
        overlap = 1'b1;
        loadConfig(8'b1010_0111, PW'(3));
        checkOutput("load111_prog", 32'(progress), 0);
        checkOutput("load111_cfg_err", 32'(cfg_err), 0);
        for (int i = 0; i < 5; i++)
            stepCheck($sformatf("ovl111[%0d]", i), 1'b1, 1'b1, prog111Ovl[i], match111Ovl[i]);
        stepCheck("ovl111_idle", 1'b0, 1'b1, 3, 0);
        checkOutput("ovl111_count", 32'(match_count), 32'(CNT_ON * 3));
        overlap = 1'b0;
        loadConfig(8'b0000_0111, PW'(3));
        checkOutput("reload_count_kept", 32'(match_count), 32'(CNT_ON * 3));
        for (int i = 0; i < 5; i++)
            stepCheck($sformatf("non111[%0d]", i), 1'b1, 1'b1, prog111Non[i], match111Non[i]);

        // Enable gaps through the 1011 stream
        doReset();
        overlap = 1'b1;
        for (int i = 0; i < 9; i++)
            stepCheck($sformatf("gap[%0d]", i), 1'(enG[i]), 1'(dinG[i]), progG[i], matchG[i]);

        // Illegal length 0 forces len=MAX_W and sets the sticky error
        doReset();
        loadConfig(8'hFF, PW'(0));
        checkOutput("len0_cfg_err", 32'(cfg_err), 1);
        for (int i = 0; i < 8; i++)
            stepCheck($sformatf("len8[%0d]", i), 1'b1, 1'b1, i + 1, (i == 7) ? 1 : 0);
        loadConfig(8'h0B, PW'(4));
        checkOutput("legal_load_cfg_err", 32'(cfg_err), 1);
        doReset();
        checkOutput("reset_cfg_err", 32'(cfg_err), 0);
        loadConfig(8'h0B, PW'(9));
        checkOutput("len9_cfg_err", 32'(cfg_err), 1);

        // Asynchronous reset in the middle of a sequence
        doReset();
        overlap = 1'b1;
        for (int i = 0; i < 6; i++)
            stepCheck($sformatf("pre_rst[%0d]", i), 1'b1, 1'(bitsA[i]), progOvlA[i], matchOvlA[i]);
        checkOutput("pre_rst_count", 32'(match_count), 32'(CNT_ON * 1));
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_prog", 32'(progress), 0);
        checkOutput("async_rst_match", 32'(match), 0);
        checkOutput("async_rst_count", 32'(match_count), 0);
        rst_n = 1'b1;
        stepCheck("post_rst[0]", 1'b1, 1'b0, 0, 0);
        stepCheck("post_rst[1]", 1'b1, 1'b1, 1, 0);
        stepCheck("post_rst[2]", 1'b1, 1'b1, 1, 0);

        // Five overlapping matches saturate a 2-bit counter at 3
        doReset();
        overlap = 1'b1;
        loadConfig(8'b0000_0111, PW'(3));
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("sat_count", 32'(match_count), 32'(CNT_ON * 3));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
